// File: rtl/nco.sv
// Numerically controlled oscillator: 32-bit phase accumulator feeding a
// quarter-wave sine ROM through a 3-stage pipeline. Define NCO_COS_EN to add fcos_o.
module nco (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [31:0] phi_inc_i,
  output logic [11:0] fsin_o,
`ifdef NCO_COS_EN
  output logic [11:0] fcos_o,
`endif
  output logic        out_valid
);

  // round(2047*sin(pi*i/512)) evaluated at elaboration using a 2^30 fixed-point
  // Taylor series; the error is far below the rounding step.
  function automatic logic [10:0] quarter_sine(input int i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (64'sd3373259426 * longint'(i)) / 64'sd512;
    x2   = (x * x) / 64'sd1073741824;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) / 64'sd1073741824) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    quarter_sine = 11'((sum * 64'sd2047 + 64'sd536870912) >>> 30);
  endfunction

  logic [10:0] rom_s [0:256];

  for (genvar g = 0; g < 257; g++) begin : g_rom
    localparam logic [10:0] ROM_VAL = quarter_sine(g);
    assign rom_s[g] = ROM_VAL;
  end

  logic [31:0] acc_q,  acc_d;
  logic [8:0]  idx_q,  idx_d;
  logic        sgn_q,  sgn_d;
  logic [10:0] dat_q,  dat_d;
  logic        dsgn_q, dsgn_d;
  logic [11:0] fsin_q, fsin_d;
  logic [2:0]  vld_q,  vld_d;
  logic [1:0]  quad_s;
  logic [7:0]  k_s;

`ifdef NCO_COS_EN
  logic [8:0]  cidx_q,  cidx_d;
  logic        csgn_q,  csgn_d;
  logic [10:0] cdat_q,  cdat_d;
  logic        cdsgn_q, cdsgn_d;
  logic [11:0] fcos_q,  fcos_d;
`endif

  // Next-state for accumulator, quadrant fold, ROM read and sign application.
  always_comb begin
    quad_s = acc_q[31:30];
    k_s    = acc_q[29:22];
    acc_d  = acc_q + phi_inc_i;
    if (quad_s[0]) begin
      idx_d = 9'd256 - {1'b0, k_s};
    end else begin
      idx_d = {1'b0, k_s};
    end
    sgn_d  = quad_s[1];
    dat_d  = rom_s[idx_q];
    dsgn_d = sgn_q;
    if (dsgn_q) begin
      fsin_d = 12'd0 - {1'b0, dat_q};
    end else begin
      fsin_d = {1'b0, dat_q};
    end
    vld_d = {vld_q[1:0], 1'b1};
`ifdef NCO_COS_EN
    if (quad_s[0]) begin
      cidx_d = {1'b0, k_s};
    end else begin
      cidx_d = 9'd256 - {1'b0, k_s};
    end
    csgn_d  = quad_s[1] ^ quad_s[0];
    cdat_d  = rom_s[cidx_q];
    cdsgn_d = csgn_q;
    if (cdsgn_q) begin
      fcos_d = 12'd0 - {1'b0, cdat_q};
    end else begin
      fcos_d = {1'b0, cdat_q};
    end
`endif
  end

  // Pipeline registers; reset wins over clken, clken=0 freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= 32'd0;
      idx_q   <= 9'd0;
      sgn_q   <= 1'b0;
      dat_q   <= 11'd0;
      dsgn_q  <= 1'b0;
      fsin_q  <= 12'd0;
      vld_q   <= 3'd0;
`ifdef NCO_COS_EN
      cidx_q  <= 9'd0;
      csgn_q  <= 1'b0;
      cdat_q  <= 11'd0;
      cdsgn_q <= 1'b0;
      fcos_q  <= 12'd0;
`endif
    end else if (clken) begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sgn_q   <= sgn_d;
      dat_q   <= dat_d;
      dsgn_q  <= dsgn_d;
      fsin_q  <= fsin_d;
      vld_q   <= vld_d;
`ifdef NCO_COS_EN
      cidx_q  <= cidx_d;
      csgn_q  <= csgn_d;
      cdat_q  <= cdat_d;
      cdsgn_q <= cdsgn_d;
      fcos_q  <= fcos_d;
`endif
    end
  end

  assign fsin_o    = fsin_q;
  assign out_valid = vld_q[2];
`ifdef NCO_COS_EN
  assign fcos_o    = fcos_q;
`endif

endmodule

// File: tb/tb_nco.sv
// Directed self-checking bench for nco: latency, sequences, clken hold,
// full-cycle sweep, mid-stream reset, wrap-around and zero increment.
module tb_nco;

  logic        clk;
  logic        reset;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic [11:0] fsin_o;
  logic        out_valid;
`ifdef NCO_COS_EN
  logic [11:0] fcos_o;
`endif

  int checks;
  int failures;

  int seq_fwd [8] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};
  int seq_rev [8] = '{0, -1447, -2047, -1447, 0, 1447, 2047, 1447};
`ifdef NCO_COS_EN
  int seq_cos [8] = '{2047, 1447, 0, -1447, -2047, -1447, 0, 1447};
`endif
  int sweep [1024];

  nco dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .phi_inc_i (phi_inc_i),
    .fsin_o    (fsin_o),
`ifdef NCO_COS_EN
    .fcos_o    (fcos_o),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [31:0] inc);
    reset     = 1'b1;
    clken     = 1'b1;
    phi_inc_i = inc;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int e;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    clken     = 1'b0;
    phi_inc_i = 32'h2000_0000;

    // Reset state, with clken low (reset overrides)
    tick();
    tick();
    chk("reset_fsin", int'($signed(fsin_o)), 0);
    chk("reset_valid", int'(out_valid), 0);
`ifdef NCO_COS_EN
    chk("reset_fcos", int'($signed(fcos_o)), 0);
`endif

    // Eighth-cycle increment: valid on 3rd edge, 8-sample sequence
    restart(32'h2000_0000);
    tick();
    chk("valid_edge1", int'(out_valid), 0);
    tick();
    chk("valid_edge2", int'(out_valid), 0);
    tick();
    chk("valid_edge3", int'(out_valid), 1);
    for (int n = 0; n < 16; n++) begin
      chk("seq_eighth", int'($signed(fsin_o)), seq_fwd[n % 8]);
`ifdef NCO_COS_EN
      chk("seq_cos", int'($signed(fcos_o)), seq_cos[n % 8]);
`endif
      tick();
    end
    chk("valid_stays", int'(out_valid), 1);

    // clken toggling: sequence unchanged, values held while disabled
    restart(32'h2000_0000);
    e = 0;
    for (int c = 0; c < 40; c++) begin
      clken = (c % 2 == 0);
      tick();
      if (clken) e++;
      chk("clken_valid", int'(out_valid), (e >= 3) ? 1 : 0);
      if (e >= 3) chk("clken_seq", int'($signed(fsin_o)), seq_fwd[(e - 3) % 8]);
    end
    clken = 1'b1;

    // One ROM step per sample over a full cycle
    restart(32'h0040_0000);
    tick();
    tick();
    tick();
    for (int n = 0; n < 1024; n++) begin
      sweep[n] = int'($signed(fsin_o));
      tick();
    end
    for (int n = 0; n < 1024; n++) begin
      chk("sweep_range", ((sweep[n] <= 2047) && (sweep[n] >= -2047)) ? 1 : 0, 1);
    end
    chk("sweep_0", sweep[0], 0);
    chk("sweep_128", sweep[128], 1447);
    chk("sweep_256", sweep[256], 2047);
    chk("sweep_384", sweep[384], 1447);
    chk("sweep_512", sweep[512], 0);
    chk("sweep_640", sweep[640], -1447);
    chk("sweep_768", sweep[768], -2047);
    for (int j = 1; j < 512; j++) begin
      chk("sweep_odd_sym", sweep[512 + j], -sweep[512 - j]);
    end
    for (int j = 1; j < 256; j++) begin
      chk("sweep_quarter_sym", sweep[256 + j], sweep[256 - j]);
    end

    // Mid-stream reset restarts phase at 0
    restart(32'h2000_0000);
    for (int n = 0; n < 6; n++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_fsin", int'($signed(fsin_o)), 0);
    chk("midrst_valid", int'(out_valid), 0);
    reset = 1'b0;
    tick();
    tick();
    chk("midrst_valid_edge2", int'(out_valid), 0);
    tick();
    chk("midrst_valid_edge3", int'(out_valid), 1);
    for (int n = 0; n < 8; n++) begin
      chk("midrst_seq", int'($signed(fsin_o)), seq_fwd[n]);
      tick();
    end

    // Negative increment wraps modulo 2^32
    restart(32'hE000_0000);
    tick();
    tick();
    tick();
    for (int n = 0; n < 16; n++) begin
      chk("wrap_seq", int'($signed(fsin_o)), seq_rev[n % 8]);
      tick();
    end

    // Half-cycle increment alternates phase 0 and pi
    restart(32'h8000_0000);
    tick();
    tick();
    tick();
    for (int n = 0; n < 6; n++) begin
      chk("half_seq", int'($signed(fsin_o)), 0);
      tick();
    end

    // Zero increment after one step holds the phase at pi/4
    restart(32'h2000_0000);
    tick();
    phi_inc_i = 32'h0000_0000;
    tick();
    tick();
    chk("hold_first", int'($signed(fsin_o)), 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("hold_const", int'($signed(fsin_o)), 1447);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nco.md
# nco

Numerically controlled oscillator producing a 12-bit signed sine sample per enabled clock from a 32-bit phase-increment word. It sits in the digital up/down-conversion datapath as the local-oscillator source. Output frequency is f_clk · phi_inc_i / 2^32. The output is valid after a fixed pipeline fill.

## Interface

Parameters: none. Widths are fixed.

Ports (reset is synchronous and active-high; one clock):
- clk  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- clken  input  1  clock enable; when low, all registers hold
- phi_inc_i  input  32  unsigned phase increment per enabled cycle
- fsin_o  output  12  two's-complement sine sample
- out_valid  output  1  high when fsin_o carries a pipeline-filled sample

## Operation

- Phase accumulator `acc`, 32 bits:
  - acc <= acc + phi_inc_i on each enabled cycle.
  - Wraps modulo 2^32; carry out is discarded.
  - phi_inc_i is sampled every enabled cycle and may change at any time.
- Phase truncation: p = acc[31:22] (10 bits, 1024 points per cycle). Lower bits are discarded; no dither.
- Quadrant fold:
  - q = p[9:8], k = p[7:0].
  - Quarter-wave ROM with 257 entries, index 0..256, each 11 bits unsigned.
  - ROM[i] = round(2047·sin(π·i/512)). ROM[0]=0, ROM[128]=1447, ROM[256]=2047.
  - ROM index: i = k for q=0 and q=2; i = 256−k for q=1 and q=3.
  - Sign: positive for q=0 and q=1; negated (two's complement) for q=2 and q=3.
- Output range is −2047..+2047. −2048 is never produced.
- Pipeline, each stage advancing only when clken=1:
  1. S0: acc register.
  2. S1: registers ROM index and sign from acc.
  3. S2: registers ROM data and sign.
  4. S3: registers fsin_o, the signed result.
- Valid tracking: a 3-bit valid shift register. A 1 enters on each enabled cycle after reset. out_valid is the last bit.

## Timing

- Reset (reset=1 at a rising edge) clears acc, all pipeline registers, fsin_o and the valid shift register.
  - Reset values: acc=0, fsin_o=0, out_valid=0.
  - Reset overrides clken.
- Latency: a sample derived from acc value A appears on fsin_o 3 enabled cycles after A is registered.
- The first valid fsin_o corresponds to acc=0 and equals 0.
- out_valid rises on the 3rd enabled rising edge after reset deasserts. It stays high until the next reset.
- clken=0 freezes acc, the pipeline, fsin_o and out_valid at their current values. There is no bubble or loss of phase.
- Reset asserted mid-stream returns the block to the post-reset state on the next edge. Phase restarts at 0.
- phi_inc_i=0 holds the current phase: constant output.
- phi_inc_i=0x80000000 alternates phase 0 and π, giving output 0, 0, ...

## Configuration

- Macro NCO_COS_EN:
  - Defined: adds output port fcos_o (12 bits, two's complement), a cosine from the same phase.
    - ROM index: i = 256−k for q=0 and q=2; i = k for q=1 and q=3.
    - Sign: negative for q=1 and q=2.
    - Same latency as fsin_o; reset value 0; covered by out_valid.
    - Uses a second ROM read port.
  - Undefined: no fcos_o port and no extra logic. fsin_o behaviour is identical in both builds.

## Test plan

- Reset, then clken=1 and phi_inc_i=0x20000000 -> out_valid rises on the 3rd edge after release.
  - fsin_o sequence repeats every 8 samples: 0, 1447, 2047, 1447, 0, −1447, −2047, −1447.
- Same stimulus with clken toggled 1,0,1,0 -> output sequence unchanged; values hold during clken=0 cycles.
- phi_inc_i=0x00400000 (one ROM step per sample) for 1024 samples -> all values within ±2047.
  - Peak +2047 at sample 256 and −2047 at sample 768.
  - Sequence odd-symmetric about sample 512.
- Reset asserted mid-stream at phi_inc_i=0x20000000 -> next edge gives fsin_o=0 and out_valid=0; sequence restarts from 0.
- Wrap-around: phi_inc_i=0xE0000000 (−1/8 cycle) -> sequence 0, −1447, −2047, −1447, 0, 1447, 2047, 1447.
- With NCO_COS_EN and phi_inc_i=0x20000000 -> fcos_o sequence: 2047, 1447, 0, −1447, −2047, −1447, 0, 1447.
